// File: rtl/bus_resp_pkg.sv
// Shared definitions for the bus_responder slice.
//   io_reg_e     : register offsets inside the 4-byte I/O window
//   Stat*        : bit positions inside the STATUS byte
//   *Rst         : reset values for byte- and timer-wide state
//   status_byte(): packs the STATUS flags into the byte the CPU reads
package bus_resp_pkg;

  typedef enum logic [1:0] {
    IoData   = 2'd0,
    IoStatus = 2'd1,
    IoTimerL = 2'd2,
    IoTimerH = 2'd3
  } io_reg_e;

  // STATUS read layout: {4'b0, OVF, TXFULL, TXEMPTY, RXV}
  localparam int unsigned StatRxv     = 0;
  localparam int unsigned StatTxEmpty = 1;
  localparam int unsigned StatTxFull  = 2;
  localparam int unsigned StatOvf     = 3;

  // STATUS write: a 1 in these DO bits clears the matching flag
  localparam int unsigned ClrRxvBit = 0;
  localparam int unsigned ClrOvfBit = 3;

  localparam logic [7:0]  ByteRst  = 8'h00;
  localparam logic [15:0] TimerRst = 16'h0000;

  function automatic logic [7:0] status_byte(input logic ovf, input logic tx_full,
                                             input logic tx_empty, input logic rxv);
    logic [7:0] s;
    s              = '0;
    s[StatOvf]     = ovf;
    s[StatTxFull]  = tx_full;
    s[StatTxEmpty] = tx_empty;
    s[StatRxv]     = rxv;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide synchronous FIFO used as the TX queue of bus_responder.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (discards contents)
//   push, din  : enqueue din; ignored while full (full is the registered state)
//   pop        : dequeue the head; ignored while empty
//   full/empty : registered occupancy flags
//   count      : current number of entries, $clog2(DEPTH)+1 bits
//   head       : oldest entry, forced to 0 while empty
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned Aw   = $clog2(DEPTH),
  localparam int unsigned Cw   = Aw + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic          full,
  output logic          empty,
  output logic [Cw-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [Aw-1:0] wr_ptr_q;
  logic [Aw-1:0] rd_ptr_q;
  logic [Cw-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == Cw'(DEPTH));
  assign empty = (count_q == '0);

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + Aw'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + Aw'(1);
      count_q <= count_q + Cw'(push_ok) - Cw'(pop_ok);
    end
  end

  // Storage is not reset; the empty flag masks stale data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  assign head  = empty ? 8'h00 : mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/bus_responder.sv
// Target side of the CPU memory bus (AB/DO/DI/RW). Every cycle it returns RAM or
// memory-mapped I/O data on DI and performs writes.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   AB, DO, RW          : CPU address, write data, 1 = write
//   DI                  : read data, combinational; 0 during writes and for unmapped space
//   tx_data/valid/ready : TX FIFO head, drained by an external consumer
//   rx_data/valid/ready : RX holding register, filled by an external producer
// I/O window at IO_BASE: +0 DATA, +1 STATUS, +2 TIMER_L, +3 TIMER_H.
// Build option: define BUS_RESP_TIMER_EN to include the free-running timer and its
// snapshot registers; otherwise TIMER_L/TIMER_H read 0 and ignore writes.
module bus_responder
  import bus_resp_pkg::*;
#(
  parameter int unsigned RAM_AW     = 12,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        RW,
  output logic [7:0]  DI,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned CntW     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RamWords = 2 ** RAM_AW;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic    ram_hit;
  logic    io_hit;
  io_reg_e io_reg;

  assign ram_hit = ((32'(AB) >> RAM_AW) == 32'd0);
  // RAM takes priority should the window ever be placed inside RAM space.
  assign io_hit  = (AB[15:2] == IO_BASE[15:2]) & ~ram_hit;
  assign io_reg  = io_reg_e'(AB[1:0]);

  // ---------------------------------------------------------------------------
  // Write-event detect: the CPU may hold RW=1 on one address for several cycles,
  // so I/O side effects fire only on the first cycle of such a run.
  // ---------------------------------------------------------------------------
  logic        rw_q;
  logic [15:0] ab_q;
  logic        wr_evt;
  logic        io_wr;
  logic        tx_push;
  logic        stat_wr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rw_q <= 1'b0;
      ab_q <= '0;
    end else begin
      rw_q <= RW;
      ab_q <= AB;
    end
  end

  assign wr_evt  = RW & (~rw_q | (AB != ab_q));
  assign io_wr   = wr_evt & io_hit;
  assign tx_push = io_wr & (io_reg == IoData);
  assign stat_wr = io_wr & (io_reg == IoStatus);

  // ---------------------------------------------------------------------------
  // RAM: written on every RW=1 cycle, repeats are harmless. Not reset.
  // ---------------------------------------------------------------------------
  logic [7:0] ram [RamWords];

  always_ff @(posedge CLK) begin
    if (RW && ram_hit) ram[AB[RAM_AW-1:0]] <= DO;
  end

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic            tx_full;
  logic            tx_empty;
  logic            tx_pop;
  logic [CntW-1:0] tx_count;

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (DO),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_data)
  );

  // ---------------------------------------------------------------------------
  // Overflow flag: sticky, set by a dropped push; set beats a same-cycle clear.
  // ---------------------------------------------------------------------------
  logic ovf_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q <= 1'b0;
    end else if (tx_push && tx_full) begin
      ovf_q <= 1'b1;
    end else if (stat_wr && DO[ClrOvfBit]) begin
      ovf_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX holding register. Capture needs rxv_q=0 and clear only matters when
  // rxv_q=1, so the two never compete.
  // ---------------------------------------------------------------------------
  logic       rxv_q;
  logic [7:0] rx_byte_q;

  assign rx_ready = ~rxv_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rxv_q     <= 1'b0;
      rx_byte_q <= ByteRst;
    end else if (rx_valid && rx_ready) begin
      rxv_q     <= 1'b1;
      rx_byte_q <= rx_data;
    end else if (stat_wr && DO[ClrRxvBit]) begin
      rxv_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Timer and snapshot
  // ---------------------------------------------------------------------------
  logic [7:0] timer_lo;
  logic [7:0] timer_hi;

`ifdef BUS_RESP_TIMER_EN
  logic [15:0] timer_q;
  logic [15:0] shadow_q;
  logic        snap_wr;

  // Any TIMER_L write latches both bytes at once so a later read pair is coherent.
  assign snap_wr = io_wr & (io_reg == IoTimerL);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      timer_q  <= TimerRst;
      shadow_q <= TimerRst;
    end else begin
      timer_q <= timer_q + 16'd1;
      if (snap_wr) shadow_q <= timer_q;
    end
  end

  assign timer_lo = shadow_q[7:0];
  assign timer_hi = shadow_q[15:8];
`else
  assign timer_lo = ByteRst;
  assign timer_hi = ByteRst;
`endif

  // ---------------------------------------------------------------------------
  // Read mux: zero latency, no side effects.
  // ---------------------------------------------------------------------------
  logic [7:0] status;

  assign status = status_byte(ovf_q, (tx_count == CntW'(FIFO_DEPTH)), (tx_count == '0),
                              rxv_q);

  always_comb begin
    DI = ByteRst;
    if (!RW) begin
      if (ram_hit) begin
        DI = ram[AB[RAM_AW-1:0]];
      end else if (io_hit) begin
        unique case (io_reg)
          IoData:   DI = rx_byte_q;
          IoStatus: DI = status;
          IoTimerL: DI = timer_lo;
          IoTimerH: DI = timer_hi;
          default:  DI = ByteRst;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder. Stimulus queues expected values; a monitor on the
// falling edge pops them and compares against the live outputs, and independently checks
// every TX handshake against the queue of bytes expected to leave the FIFO.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ab;
  logic [7:0]  bus_do;
  logic        rw;
  logic [7:0]  di;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  always #5 clk = ~clk;

  bus_responder dut (
    .CLK      (clk),
    .RESET    (reset),
    .AB       (ab),
    .DO       (bus_do),
    .RW       (rw),
    .DI       (di),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  localparam logic [15:0] ADATA = 16'hFF00;
  localparam logic [15:0] ASTAT = 16'hFF01;
  localparam logic [15:0] ATL   = 16'hFF02;
  localparam logic [15:0] ATH   = 16'hFF03;

  // Observation selectors
  localparam int SelDi = 0, SelRxReady = 1, SelTxValid = 2, SelTxData = 3, SelTxLeft = 4;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SelDi:      return di;
      SelRxReady: return {7'b0, rx_ready};
      SelTxValid: return {7'b0, tx_valid};
      SelTxData:  return tx_data;
      default:    return 8'(tx_q.size());
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] got;
    logic [7:0] txe;
    while (rd_q.size() > 0) begin
      e   = rd_q.pop_front();
      got = observe(e.sel);
      checks++;
      if (got !== e.val) begin
        errors++;
        $display("FAIL %s: got %02h expected %02h", e.name, got, e.val);
      end
    end
    if (tx_valid && tx_ready) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %02h expected no byte", tx_data);
      end else begin
        txe = tx_q.pop_front();
        if (tx_data !== txe) begin
          errors++;
          $display("FAIL tx_byte: got %02h expected %02h", tx_data, txe);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw     = 1'b0;
    ab     = 16'h0000;
    bus_do = 8'h00;
  endtask

  task automatic chk(input string n, input int sel, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.val  = v;
    rd_q.push_back(e);
  endtask

  task automatic rd(input string n, input logic [15:0] a, input logic [7:0] v);
    rw = 1'b0;
    ab = a;
    chk(n, SelDi, v);
    cyc();
  endtask

  // Two-cycle write (second cycle must not repeat I/O side effects), then one idle cycle.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    rw     = 1'b1;
    ab     = a;
    bus_do = d;
    cyc();
    cyc();
    idle();
    cyc();
  endtask

  task automatic drain(input string n);
    tx_ready = 1'b1;
    for (int i = 0; i < 50 && tx_valid; i++) cyc();
    tx_ready = 1'b0;
    chk(n, SelTxValid, 8'h00);
    chk({n, "_left"}, SelTxLeft, 8'h00);
    cyc();
  endtask

  initial begin
    reset    = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle();
    repeat (2) cyc();
    reset = 1'b0;

    // Reset state
    ab = ASTAT;
    chk("rst_status", SelDi, 8'h02);
    chk("rst_tx_valid", SelTxValid, 8'h00);
    chk("rst_tx_data", SelTxData, 8'h00);
    chk("rst_rx_ready", SelRxReady, 8'h01);
    cyc();

    // 1: RAM write/read, unmapped space
    rw = 1'b1; ab = 16'h0100; bus_do = 8'hAA;
    chk("di_during_write", SelDi, 8'h00);
    repeat (3) cyc();
    rd("ram_0100", 16'h0100, 8'hAA);
    rd("unmapped_5000", 16'h5000, 8'h00);
    wr(16'h5000, 8'h77);
    rd("unmapped_after_wr", 16'h5000, 8'h00);
    rd("unmapped_fefc", 16'hFEFC, 8'h00);
    rd("ram_0100_again", 16'h0100, 8'hAA);

    // 2: two pushes, each held for two cycles
    wr(ADATA, 8'h11); tx_q.push_back(8'h11);
    wr(ADATA, 8'h22); tx_q.push_back(8'h22);
    rd("status_two_entries", ASTAT, 8'h00);
    chk("head_11", SelTxData, 8'h11);
    cyc();
    drain("drain_two");
    rd("status_empty", ASTAT, 8'h02);

    // 3: overflow
    for (int i = 0; i < 9; i++) begin
      wr(ADATA, 8'(8'h80 + i));
      if (i < 8) tx_q.push_back(8'(8'h80 + i));
    end
    rd("status_full_ovf", ASTAT, 8'h0C);
    wr(ASTAT, 8'h08);
    rd("status_ovf_cleared", ASTAT, 8'h04);
    rw = 1'b1; ab = ADATA; bus_do = 8'h99; tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    idle();
    cyc();
    rd("status_push_pop_full", ASTAT, 8'h08);
    drain("drain_eight");
    wr(ASTAT, 8'h08);
    rd("status_after_ovf_clr", ASTAT, 8'h02);

    // 4: RX holding register
    rx_valid = 1'b1; rx_data = 8'h5A;
    cyc();
    rx_data = 8'h33;
    chk("rx_ready_held", SelRxReady, 8'h00);
    rd("rx_data_5a", ADATA, 8'h5A);
    rd("rx_data_5a_no_side_effect", ADATA, 8'h5A);
    rd("status_rxv", ASTAT, 8'h03);
    wr(ASTAT, 8'h01);
    rx_valid = 1'b0;
    chk("rx_ready_second", SelRxReady, 8'h00);
    rd("rx_data_33", ADATA, 8'h33);
    wr(ASTAT, 8'h01);
    chk("rx_ready_cleared", SelRxReady, 8'h01);
    rd("status_rx_cleared", ASTAT, 8'h02);

    // 6: reset with pending FIFO entries and RXV set (entries are discarded)
    wr(ADATA, 8'h01);
    wr(ADATA, 8'h02);
    wr(ADATA, 8'h03);
    rx_valid = 1'b1; rx_data = 8'h44;
    cyc();
    rx_valid = 1'b0;
    rd("status_pre_reset", ASTAT, 8'h01);
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    ab = ASTAT;
    chk("mid_reset_status", SelDi, 8'h02);
    chk("mid_reset_tx_valid", SelTxValid, 8'h00);
    chk("mid_reset_tx_data", SelTxData, 8'h00);
    chk("mid_reset_rx_ready", SelRxReady, 8'h01);
    cyc();

    // 5: timer snapshot 300 cycles after the reset edge
    repeat (299) cyc();
    wr(ATL, 8'h00);
`ifdef BUS_RESP_TIMER_EN
    rd("timer_l", ATL, 8'h2C);
    rd("timer_h", ATH, 8'h01);
    repeat (5) cyc();
    rd("timer_l_stable", ATL, 8'h2C);
    rd("timer_h_stable", ATH, 8'h01);
`else
    rd("timer_l_absent", ATL, 8'h00);
    rd("timer_h_absent", ATH, 8'h00);
`endif
    rd("rx_data_after_reset", ADATA, 8'h00);

    chk("tx_scoreboard_empty", SelTxLeft, 8'h00);
    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
